// File: rtl/edge_detect_multi.sv
// ============================================================================
// Module      : edge_detect_multi
// Description : Multi-channel edge detector. Each channel synchronises an
//               asynchronous level input, optionally deglitches it, and emits
//               one-cycle rise/fall pulses, a mode-gated event pulse, a sticky
//               pending flag and a saturating event counter. irq is the OR of
//               all pending flags.
// Option      : EDGE_DETECT_FILTER_EN - when defined, a level change must be
//               seen on FILTER_CYCLES consecutive synchronised samples before
//               it is accepted; shorter glitches are discarded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detect_multi #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS-1:0]       rise,
  output logic [CHANNELS-1:0]       fall,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       pending,
  output logic [CHANNELS*CNT_W-1:0] count,
  output logic                      irq
);

  // Event-selection encodings of the shared mode input.
  localparam logic [1:0] C_MODE_RISE = 2'b00;
  localparam logic [1:0] C_MODE_FALL = 2'b01;
  localparam logic [1:0] C_MODE_BOTH = 2'b10;

  // Reject out-of-range parameterisations at elaboration time.
  if (CHANNELS < 1 || SYNC_STAGES < 2 || FILTER_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("edge_detect_multi: parameter out of range");
  end

  // Mode decode is shared by every channel; it is sampled together with the
  // event it gates, so a mode change applies from the edge that samples it.
  logic w_sel_rise;
  logic w_sel_fall;

  // Decode which transition directions generate a pulse.
  always_comb begin
    w_sel_rise = (mode == C_MODE_RISE) || (mode == C_MODE_BOTH);
    w_sel_fall = (mode == C_MODE_FALL) || (mode == C_MODE_BOTH);
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   pulse_q;
    logic                   pulse_d;
    logic                   pending_q;
    logic                   pending_d;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   w_s;
    logic                   w_pulse_ev;

    // Synchronised level is the last stage of the shift chain.
    assign w_s = sync_q[SYNC_STAGES-1];

    // Shift the raw input into the synchroniser chain (bit 0 samples first).
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], in[gi]};
    end

`ifdef EDGE_DETECT_FILTER_EN
    localparam int               FC_W      = $clog2(FILTER_CYCLES + 1);
    localparam logic [FC_W-1:0]  C_FC_LAST = FC_W'(FILTER_CYCLES - 1);
    localparam logic [FC_W-1:0]  C_FC_ONE  = FC_W'(1);

    logic [FC_W-1:0] fc_q;
    logic [FC_W-1:0] fc_d;

    // Deglitch: count consecutive samples that differ from the accepted
    // level; accept on the FILTER_CYCLES-th one, restart on any agreement.
    always_comb begin
      fc_d    = '0;
      level_d = level_q;
      if (w_s != level_q) begin
        if (fc_q == C_FC_LAST) begin
          level_d = w_s;
        end else begin
          fc_d = fc_q + C_FC_ONE;
        end
      end
    end

    // Filter run-length register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        fc_q <= '0;
      end else begin
        fc_q <= fc_d;
      end
    end
`else
    // Unfiltered: the accepted level follows the synchronised sample directly.
    always_comb begin
      level_d = w_s;
    end
`endif

    // Every change of the accepted level yields exactly one rise or fall;
    // pulse is the mode-gated copy produced on the same edge.
    always_comb begin
      rise_d     = level_d & ~level_q;
      fall_d     = ~level_d & level_q;
      w_pulse_ev = (rise_d & w_sel_rise) | (fall_d & w_sel_fall);
      pulse_d    = w_pulse_ev;
    end

    // Sticky pending and saturating counter; a simultaneous event beats clear.
    always_comb begin
      pending_d = w_pulse_ev | (pending_q & ~clear[gi]);
      count_d   = count_q;
      if (clear[gi]) begin
        count_d = w_pulse_ev ? CNT_W'(1) : '0;
      end else if (w_pulse_ev && (count_q != {CNT_W{1'b1}})) begin
        count_d = count_q + CNT_W'(1);
      end
    end

    // Per-channel state register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q    <= '0;
        level_q   <= 1'b0;
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
        pulse_q   <= 1'b0;
        pending_q <= 1'b0;
        count_q   <= '0;
      end else begin
        sync_q    <= sync_d;
        level_q   <= level_d;
        rise_q    <= rise_d;
        fall_q    <= fall_d;
        pulse_q   <= pulse_d;
        pending_q <= pending_d;
        count_q   <= count_d;
      end
    end

    assign rise[gi]                   = rise_q;
    assign fall[gi]                   = fall_q;
    assign pulse[gi]                  = pulse_q;
    assign pending[gi]                = pending_q;
    assign count[gi*CNT_W +: CNT_W]   = count_q;
  end

  // Interrupt request straight from the pending registers.
  assign irq = |pending;

endmodule

`default_nettype wire

// File: tb/tb_edge_detect_multi.sv
// ============================================================================
// Module      : tb_edge_detect_multi
// Description : Self-checking bench for edge_detect_multi with a behavioural
//               reference model driven by directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_detect_multi;

  localparam int CH    = 4;
  localparam int SYNC  = 2;
  localparam int FC    = 4;
  localparam int CNT_W = 8;
  localparam int HD    = SYNC + FC;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef EDGE_DETECT_FILTER_EN
  localparam int LAT   = SYNC + FC - 1;
  localparam int HOLD  = FC + 1;
`else
  localparam int LAT   = SYNC;
  localparam int HOLD  = 2;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [CH-1:0]          in_r = '0;
  logic [1:0]             mode_r = 2'b00;
  logic [CH-1:0]          clear_r = '0;
  logic [CH-1:0]          rise_o;
  logic [CH-1:0]          fall_o;
  logic [CH-1:0]          pulse_o;
  logic [CH-1:0]          pend_o;
  logic [CH*CNT_W-1:0]    cnt_o;
  logic                   irq_o;

  int checks = 0;
  int errors = 0;

  // Reference model: history of sampled inputs plus architectural outputs.
  logic [CH-1:0] hist [HD];
  logic [CH-1:0] m_level, m_rise, m_fall, m_pulse, m_pend;
  int            m_cnt [CH];
  logic [CH-1:0] rise_seen;

  edge_detect_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in(in_r), .mode(mode_r), .clear(clear_r),
    .rise(rise_o), .fall(fall_o), .pulse(pulse_o), .pending(pend_o),
    .count(cnt_o), .irq(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < HD; k++) hist[k] = '0;
    m_level = '0; m_rise = '0; m_fall = '0; m_pulse = '0; m_pend = '0;
    for (int c = 0; c < CH; c++) m_cnt[c] = 0;
  endtask

  // One clock edge of the specification's behaviour, given inputs sampled there.
  task automatic model_edge(input logic [CH-1:0] a_in, input logic [1:0] a_mode,
                            input logic [CH-1:0] a_clear);
    logic nl, ev;
    for (int c = 0; c < CH; c++) begin
`ifdef EDGE_DETECT_FILTER_EN
      nl = ~m_level[c];
      for (int k = 0; k < FC; k++)
        if (hist[SYNC-1+k][c] == m_level[c]) nl = m_level[c];
`else
      nl = hist[SYNC-1][c];
`endif
      m_rise[c] = nl && !m_level[c];
      m_fall[c] = !nl && m_level[c];
      m_level[c] = nl;
      case (a_mode)
        2'd0:    ev = m_rise[c];
        2'd1:    ev = m_fall[c];
        2'd2:    ev = m_rise[c] || m_fall[c];
        default: ev = 1'b0;
      endcase
      m_pulse[c] = ev;
      m_pend[c]  = ev || (m_pend[c] && !a_clear[c]);
      if (a_clear[c]) m_cnt[c] = ev ? 1 : 0;
      else if (ev && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
    end
    for (int k = HD - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = a_in;
  endtask

  task automatic check_all();
    logic [CH*CNT_W-1:0] mc;
    for (int c = 0; c < CH; c++) mc[c*CNT_W +: CNT_W] = m_cnt[c][CNT_W-1:0];
    chk("rise",    64'(rise_o),  64'(m_rise));
    chk("fall",    64'(fall_o),  64'(m_fall));
    chk("pulse",   64'(pulse_o), 64'(m_pulse));
    chk("pending", 64'(pend_o),  64'(m_pend));
    chk("count",   64'(cnt_o),   64'(mc));
    chk("irq",     64'(irq_o),   64'(|m_pend));
  endtask

  // Apply inputs away from the edge, clock once, then compare to the model.
  task automatic step(input logic [CH-1:0] a_in, input logic [1:0] a_mode,
                      input logic [CH-1:0] a_clear);
    in_r = a_in; mode_r = a_mode; clear_r = a_clear;
    @(posedge clk);
    model_edge(a_in, a_mode, a_clear);
    #1;
    check_all();
    rise_seen = rise_seen | rise_o;
  endtask

  initial begin
    logic [CH-1:0] v;
    logic [1:0]    md;
    model_reset();
    rise_seen = '0;

    // 1: all inputs high across reset release, rising mode.
    in_r = 4'hF;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rise", 64'(rise_o), 64'h0);
    chk("reset_count", 64'(cnt_o), 64'h0);
    chk("reset_irq", 64'(irq_o), 64'h0);
    reset = 1'b0;
    for (int i = 0; i < LAT; i++) step(4'hF, 2'b00, 4'h0);
    step(4'hF, 2'b00, 4'h0);
    chk("t1_rise_all", 64'(rise_o), 64'hF);
    step(4'hF, 2'b00, 4'h0);
    chk("t1_rise_one_cycle", 64'(rise_o), 64'h0);
    chk("t1_pending", 64'(pend_o), 64'hF);
    chk("t1_irq", 64'(irq_o), 64'h1);
    chk("t1_counts", 64'(cnt_o), 64'h01010101);

    // 2: single-channel rise then fall in rising mode.
    for (int i = 0; i < HD + 4; i++) step(4'h0, 2'b00, 4'h0);
    step(4'h0, 2'b00, 4'hF);
    step(4'h1, 2'b00, 4'h0);
    for (int i = 0; i < LAT - 1; i++) step(4'h1, 2'b00, 4'h0);
    step(4'h1, 2'b00, 4'h0);
    chk("t2_rise0", 64'(rise_o[0]), 64'h1);
    chk("t2_pulse0", 64'(pulse_o[0]), 64'h1);
    step(4'h1, 2'b00, 4'h0);
    chk("t2_rise0_drop", 64'(rise_o[0]), 64'h0);
    step(4'h0, 2'b00, 4'h0);
    for (int i = 0; i < LAT - 1; i++) step(4'h0, 2'b00, 4'h0);
    step(4'h0, 2'b00, 4'h0);
    chk("t2_fall0", 64'(fall_o[0]), 64'h1);
    chk("t2_fall0_nopulse", 64'(pulse_o[0]), 64'h0);

`ifdef EDGE_DETECT_FILTER_EN
    // 3: glitch of FC-1 samples is rejected, a long pulse is accepted at E0+5.
    rise_seen = '0;
    for (int i = 0; i < FC - 1; i++) step(4'h2, 2'b00, 4'h0);
    for (int i = 0; i < HD + 4; i++) step(4'h0, 2'b00, 4'h0);
    chk("t3_glitch_dropped", 64'(rise_seen[1]), 64'h0);
    for (int i = 0; i < LAT; i++) step(4'h2, 2'b00, 4'h0);
    step(4'h2, 2'b00, 4'h0);
    chk("t3_filtered_rise", 64'(rise_o[1]), 64'h1);
    for (int i = 0; i < HD + 4; i++) step(4'h0, 2'b00, 4'h0);
`endif

    // 4: both-edge mode, 300 toggles on channel 2 saturate its counter.
    step(4'h0, 2'b10, 4'hF);
    v = 4'h0;
    for (int t = 0; t < 300; t++) begin
      v[2] = ~v[2];
      for (int h = 0; h < HOLD; h++) step(v, 2'b10, 4'h0);
    end
    for (int i = 0; i < HD + 2; i++) step(v, 2'b10, 4'h0);
    chk("t4_saturate", 64'(cnt_o[2*CNT_W +: CNT_W]), 64'(CMAX));

    // 5: clear coinciding with an event on channel 3, then clear alone.
    for (int i = 0; i < HD + 2; i++) step(4'h0, 2'b00, 4'h0);
    step(4'h0, 2'b00, 4'hF);
    for (int i = 0; i < LAT; i++) step(4'h8, 2'b00, 4'h0);
    step(4'h8, 2'b00, 4'h8);
    chk("t5_set_wins", 64'(pend_o[3]), 64'h1);
    chk("t5_count_one", 64'(cnt_o[3*CNT_W +: CNT_W]), 64'h1);
    step(4'h8, 2'b00, 4'h8);
    chk("t5_clear_pend", 64'(pend_o[3]), 64'h0);
    chk("t5_clear_count", 64'(cnt_o[3*CNT_W +: CNT_W]), 64'h0);
    chk("t5_irq_low", 64'(irq_o), 64'h0);

    // Random traffic on all channels with occasional mode changes and clears.
    v = 4'h8;
    md = 2'b10;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) v[c] = ~v[c];
      if ($urandom_range(0, 49) == 0) md = 2'($urandom_range(0, 3));
      step(v, md, ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0);
    end

    // 6: asynchronous reset in the middle of toggling.
    for (int i = 0; i < 3 * HOLD; i++) begin
      if (i % HOLD == 0) v = ~v;
      step(v, 2'b10, 4'h0);
    end
    reset = 1'b1;
    #1;
    chk("t6_async_pend", 64'(pend_o), 64'h0);
    chk("t6_async_count", 64'(cnt_o), 64'h0);
    chk("t6_async_irq", 64'(irq_o), 64'h0);
    chk("t6_async_edges", 64'({rise_o, fall_o, pulse_o}), 64'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 6b: mode none still produces rise/fall but no pulse, pending or count.
    rise_seen = '0;
    v = 4'h0;
    for (int t = 0; t < 4; t++) begin
      v[0] = ~v[0];
      for (int h = 0; h < LAT + 2; h++) step(v, 2'b11, 4'h0);
    end
    chk("t6_none_rise_seen", 64'(rise_seen[0]), 64'h1);
    chk("t6_none_pending", 64'(pend_o), 64'h0);
    chk("t6_none_count", 64'(cnt_o), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
